i2c_slave_mem: RTL and testbench
================================

Name: i2c_slave_mem

Overview:
- I2C target (responder) that models a serial EEPROM on the same two-wire bus the i2c_drive master uses.
- Samples SCL/SDA with sys_clk, decodes START/STOP, device address, 1- or 2-byte word address and data bytes.
- Backed by an internal byte memory. Supports byte/page write, current-address read, random read (repeated START) and sequential read.
- Used as the bus partner for top-level simulation of top_iic and as an on-chip loopback target.

Parameters:
- SLAVE_ADDRESS, 7'b1010_000, 7-bit device address this target answers to.
- ADDR_WIDTH, 1'b1, 1: two word-address bytes (high then low); 0: one word-address byte.
- MEM_AW, 8, memory index width; depth = 2**MEM_AW bytes.

Ports:
- sys_clk, input, 1, system clock (50 MHz nominal).
- sys_rst, input, 1, asynchronous active-high reset.
- scl, input, 1, I2C clock from master.
- sda, inout, 1, I2C data, open-drain: driven 0 or released to Z, never driven 1.
- busy, output, 1, high from START detection to STOP detection.
- wr_en, output, 1, one-cycle pulse per data byte committed to memory.
- wr_addr, output, MEM_AW, memory index written on wr_en.
- wr_data, output, 8, byte written on wr_en.

Behaviour:
- Input sampling: scl and sda each pass through a 2-flop synchronizer plus one history flop.
  - SCL rise/fall = history/current edge.
  - START = synced SDA 1->0 while synced SCL is high.
  - STOP = synced SDA 0->1 while synced SCL is high.
- Data bits are sampled on the SCL rising edge, MSB first.
- The SDA drive (sda_oe) changes only on the cycle after a detected SCL falling edge. Latency from pad SCL fall to SDA change is 3 sys_clk.
- Reset values: sda released (oe=0), busy=0, wr_en=0, wr_addr=0, wr_data=0, state=IDLE, address pointer=0, bit counter=0. Memory contents are not reset.
- FSM states: IDLE, DEV_ADDR, DEV_ACK, ADDR_HI, ACK_HI, ADDR_LO, ACK_LO, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- START from any state (including repeated START mid-transfer): go to DEV_ADDR, clear bit counter, release SDA, busy=1.
- STOP from any state: go to IDLE, release SDA, busy=0. A partially received byte is discarded.
- DEV_ADDR: after 8 bits, compare bits[7:1] with SLAVE_ADDRESS.
  - Match: pull SDA low in DEV_ACK.
  - Mismatch: keep SDA released (NACK), then go to WAIT_STOP.
- DEV_ACK, SCL fall ending the ACK bit: release SDA.
  - R/W=0: go to ADDR_HI if ADDR_WIDTH=1, else ADDR_LO.
  - R/W=1: go to RD_DATA and load the shift register with mem[pointer].
- ADDR_HI then ACK_HI (always ACK): store the high byte. Only bits above the low byte that fall within MEM_AW are used; excess bits are ignored.
- ADDR_LO then ACK_LO (always ACK): pointer = {hi,lo} truncated to MEM_AW. Go to WR_DATA.
- WR_DATA then WR_ACK: after 8 bits, write the byte to mem[pointer], pulse wr_en with wr_addr/wr_data for exactly 1 cycle, ACK, pointer+1. Return to WR_DATA.
- Pointer arithmetic: MEM_AW bits, wraps 2**MEM_AW-1 -> 0. No page boundary.
- RD_DATA: present the shift-register MSB on SDA after each SCL fall (drive 0 for bit 0, release for bit 1). After the 8th bit's SCL fall, release SDA and go to RD_ACK.
- RD_ACK: sample the master's bit on SCL rise.
  - ACK (0): pointer+1, load the next byte, return to RD_DATA.
  - NACK (1): pointer+1, go to WAIT_STOP.
- WAIT_STOP: SDA released; leave only on START or STOP.
- Random read: a write sequence that stops after the address bytes, then repeated START with R/W=1, reads from the set pointer. The pointer is retained across START/STOP.
- Simultaneous START and SCL edge in the same cycle: START wins.
- Reset asserted mid-transaction: SDA released immediately (asynchronous), FSM to IDLE.

Decomposition:
- Shared package i2c_pkg: FSM state encoding, START/STOP/ACK constants, and the SLAVE_ADDRESS default shared with i2c_drive.
- One natural sub-module, i2c_bus_sync: the synchronizers plus edge/START/STOP detection. Outputs scl_rise, scl_fall, sda_s, start_det, stop_det.
- Memory is an inferred register array inside i2c_slave_mem.

Test Plan:
- Byte write, then random read:
  - Master writes 0x5A to word address 0x0012. Expect ACK on all 4 bytes and a wr_en pulse with wr_addr=0x12, wr_data=0x5A.
  - Then write address 0x0012, repeated START, read 0xA1 with NACK. Expect read byte 0x5A and SDA released after the NACK.
- Address mismatch: device byte 0xA4 (address 0x52). Expect SDA never driven low, no wr_en, busy falls on STOP.
- Wrap-around: write 0x01..0x04 starting at address 0x00FE. Expect wr_addr sequence 0xFE, 0xFF, 0x00, 0x01; then sequential read of 4 bytes from 0xFE returns 0x01..0x04.
- Current-address read: after the previous read, a device read without an address returns mem[0x02]=0x03.
- STOP mid-byte: STOP after 4 data bits of a write. Expect no wr_en, state IDLE, busy=0; the next transaction behaves normally.
- Reset mid-read while driving SDA low: sys_rst=1 releases SDA in the same cycle, busy=0, wr_en=0.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: definitions shared by the I2C target (i2c_slave_mem) and the
// i2c_drive master.
//   - state_t           : FSM state encoding of the EEPROM-style target
//   - ACK / NACK        : SDA level of the acknowledge bit
//   - RW_WRITE / RW_READ: R/W bit (LSB) of the device-address byte
//   - BITS_PER_BYTE     : bits shifted per byte before an acknowledge slot
//   - SLAVE_ADDRESS_DEFAULT : 7-bit device address shared with i2c_drive
package i2c_pkg;

    localparam logic [6:0] SLAVE_ADDRESS_DEFAULT = 7'b1010_000;

    localparam logic ACK      = 1'b0;
    localparam logic NACK     = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    localparam logic [3:0] BITS_PER_BYTE = 4'd8;

    typedef enum logic [3:0] {
        IDLE,
        DEV_ADDR,
        DEV_ACK,
        ADDR_HI,
        ACK_HI,
        ADDR_LO,
        ACK_LO,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } state_t;

endpackage

// File: rtl/i2c_slave_mem_if.sv
// i2c_slave_mem_if: SCL plus the memory-write notification and FSM
// debug signals of the I2C target. SDA is open-drain and stays a
// plain inout port of the target.
//   scl     : I2C clock from the master
//   busy    : high from START detection to STOP detection
//   wr_en   : one-cycle pulse per byte committed to memory
//   wr_addr : memory index written on wr_en
//   wr_data : byte written on wr_en
//   state   : current FSM state (debug)
// Handshake: wr_en is a valid-only strobe (no ready); wr_addr/wr_data are
// meaningful exactly in the cycle wr_en is high and the observer must
// accept every pulse.
interface i2c_slave_mem_if import i2c_pkg::*; #(
    parameter int MEM_AW = 8
) ();
    logic              scl;
    logic              busy;
    logic              wr_en;
    logic [MEM_AW-1:0] wr_addr;
    logic [7:0]        wr_data;
    state_t            state;

    modport slave  (input scl, output busy, wr_en, wr_addr, wr_data, state);
    modport master (output scl, input busy, wr_en, wr_addr, wr_data, state);
endinterface

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: brings SCL/SDA into the sys_clk domain and detects bus events.
//   inputs : sys_clk, sys_rst (async, active high), scl, sda (raw pads)
//   outputs: scl_rise/scl_fall (one-cycle), sda_s (synced SDA),
//            start_det/stop_det (one-cycle)
// Each line goes through two synchronizer flops plus one history flop;
// edges compare the history flop against the synced value.
module i2c_bus_sync (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start_det,
    output logic stop_det
);
    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_d;
    logic       sda_d;

    // Reset to the idle-bus level (both lines high) so release from reset
    // does not fabricate a START or an edge.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign sda_s     = sda_sync[1];
    assign scl_rise  =  scl_sync[1] & ~scl_d;
    assign scl_fall  = ~scl_sync[1] &  scl_d;
    assign start_det =  scl_sync[1] &  sda_d & ~sda_sync[1];
    assign stop_det  =  scl_sync[1] & ~sda_d &  sda_sync[1];

endmodule

// File: rtl/i2c_slave_mem.sv
// i2c_slave_mem: I2C target modelling a serial EEPROM backed by a byte array.
//   sys_clk, sys_rst : system clock, asynchronous active-high reset
//   sda              : open-drain data line (driven 0 or released, never 1)
//   bus (slave)      : scl in; busy, wr_en, wr_addr, wr_data, state out
// Supports byte/page write, current-address read, random read and
// sequential read. The address pointer wraps at 2**MEM_AW and survives
// START/STOP. SDA only changes in the cycle after a detected SCL fall.
module i2c_slave_mem import i2c_pkg::*; #(
    parameter logic [6:0] SLAVE_ADDRESS = SLAVE_ADDRESS_DEFAULT,
    parameter logic       ADDR_WIDTH    = 1'b1,
    parameter int         MEM_AW        = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    inout  wire               sda,
    i2c_slave_mem_if.slave    bus
);
    logic scl_rise, scl_fall, sda_s, start_det, stop_det;

    i2c_bus_sync u_sync (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .scl       (bus.scl),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .sda_s     (sda_s),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    state_t            state;
    logic [MEM_AW-1:0] ptr;
    logic [MEM_AW-1:0] ptr_next;
    logic [7:0]        addr_hi;
    logic [7:0]        shift;
    logic [3:0]        bit_cnt;
    logic              rw;
    logic              sda_oe;
    logic              busy;
    logic              wr_en;
    logic [MEM_AW-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [7:0]        mem [2**MEM_AW];
    logic [7:0]        rd_byte;
    logic [7:0]        rd_byte_next;
    logic              byte_done;
    logic              rx_state;
    logic              bus_event;
    logic              mem_we;

    assign ptr_next     = ptr + MEM_AW'(1);
    assign rd_byte      = mem[ptr];
    assign rd_byte_next = mem[ptr_next];
    assign byte_done    = (bit_cnt == BITS_PER_BYTE);
    assign rx_state     = (state == DEV_ADDR) || (state == ADDR_HI) ||
                          (state == ADDR_LO)  || (state == WR_DATA);
    // START/STOP override any SCL edge seen in the same cycle.
    assign bus_event    = start_det | stop_det;
    assign mem_we       = !bus_event && (state == WR_DATA) && scl_fall && byte_done;

    assign sda         = sda_oe ? 1'b0 : 1'bz;
    assign bus.busy    = busy;
    assign bus.wr_en   = wr_en;
    assign bus.wr_addr = wr_addr;
    assign bus.wr_data = wr_data;
    assign bus.state   = state;

    // Memory contents are deliberately not reset.
    always_ff @(posedge sys_clk) begin
        if (mem_we) mem[ptr] <= shift;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state   <= IDLE;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            ptr     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            addr_hi <= '0;
            rw      <= RW_WRITE;
        end else begin
            wr_en <= 1'b0;
            if (start_det) begin
                state   <= DEV_ADDR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                busy    <= 1'b1;
            end else if (stop_det) begin
                state   <= IDLE;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                // Receive path: MSB-first shift on SCL rise until 8 bits held;
                // RD_DATA only counts rises so it knows when the byte is out.
                if (scl_rise && !byte_done && (rx_state || state == RD_DATA)) begin
                    bit_cnt <= bit_cnt + 4'd1;
                    if (rx_state) shift <= {shift[6:0], sda_s};
                end
                case (state)
                    IDLE, WAIT_STOP: sda_oe <= 1'b0;
                    DEV_ADDR: if (scl_fall && byte_done) begin
                        bit_cnt <= '0;
                        if (shift[7:1] == SLAVE_ADDRESS) begin
                            rw     <= shift[0];
                            sda_oe <= 1'b1;
                            state  <= DEV_ACK;
                        end else begin
                            state  <= WAIT_STOP;
                        end
                    end
                    DEV_ACK: if (scl_fall) begin
                        if (rw == RW_READ) begin
                            // First data bit goes out on the fall that ends the ACK.
                            shift  <= rd_byte;
                            sda_oe <= ~rd_byte[7];
                            state  <= RD_DATA;
                        end else begin
                            sda_oe <= 1'b0;
                            state  <= ADDR_WIDTH ? ADDR_HI : ADDR_LO;
                        end
                    end
                    ADDR_HI: if (scl_fall && byte_done) begin
                        addr_hi <= shift;
                        bit_cnt <= '0;
                        sda_oe  <= 1'b1;
                        state   <= ACK_HI;
                    end
                    ACK_HI: if (scl_fall) begin
                        sda_oe <= 1'b0;
                        state  <= ADDR_LO;
                    end
                    ADDR_LO: if (scl_fall && byte_done) begin
                        ptr     <= ADDR_WIDTH ? MEM_AW'({addr_hi, shift}) : MEM_AW'(shift);
                        bit_cnt <= '0;
                        sda_oe  <= 1'b1;
                        state   <= ACK_LO;
                    end
                    ACK_LO: if (scl_fall) begin
                        sda_oe <= 1'b0;
                        state  <= WR_DATA;
                    end
                    WR_DATA: if (scl_fall && byte_done) begin
                        wr_en   <= 1'b1;
                        wr_addr <= ptr;
                        wr_data <= shift;
                        ptr     <= ptr_next;
                        bit_cnt <= '0;
                        sda_oe  <= 1'b1;
                        state   <= WR_ACK;
                    end
                    WR_ACK: if (scl_fall) begin
                        sda_oe <= 1'b0;
                        state  <= WR_DATA;
                    end
                    RD_DATA: if (scl_fall) begin
                        if (byte_done) begin
                            bit_cnt <= '0;
                            sda_oe  <= 1'b0;
                            state   <= RD_ACK;
                        end else begin
                            sda_oe <= ~shift[6];
                            shift  <= {shift[6:0], 1'b0};
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            ptr <= ptr_next;
                            if (sda_s == NACK) state <= WAIT_STOP;
                            else               shift <= rd_byte_next;
                        end else if (scl_fall) begin
                            // Only reachable after an ACK: NACK has already left.
                            sda_oe <= ~shift[7];
                            state  <= RD_DATA;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_mem.sv
// tb_i2c_slave_mem: directed bench for i2c_slave_mem acting as I2C master.
module tb_i2c_slave_mem;
    import i2c_pkg::*;

    localparam int Q = 8; // sys_clk cycles per quarter SCL period

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic m_sda_low;
    wire  sda_line;
    assign sda_line = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda_line);

    i2c_slave_mem_if #(.MEM_AW(8)) bus ();

    i2c_slave_mem #(
        .SLAVE_ADDRESS (7'h50),
        .ADDR_WIDTH    (1'b1),
        .MEM_AW        (8)
    ) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .sda     (sda_line),
        .bus     (bus)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    int slave_low_cnt = 0;
    logic [15:0] wr_exp_q[$];
    logic [7:0]  rd_exp_q[$];
    logic [15:0] exp_w;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every wr_en pulse must match the next expected {addr,data}.
    always @(negedge clk) begin
        if (!m_sda_low && sda_line === 1'b0) slave_low_cnt++;
        if (bus.wr_en === 1'b1) begin
            checks++;
            if (wr_exp_q.size() == 0) begin
                errors++;
                $error("FAIL wr_en_unexpected observed=%0h expected=none", {bus.wr_addr, bus.wr_data});
            end else begin
                exp_w = wr_exp_q.pop_front();
                assert ({bus.wr_addr, bus.wr_data} === exp_w) else begin
                    errors++;
                    $error("FAIL wr_beat observed=%0h expected=%0h", {bus.wr_addr, bus.wr_data}, exp_w);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0; wait_q();
        bus.scl   = 1'b1; wait_q();
        m_sda_low = 1'b1; wait_q();
        bus.scl   = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1; wait_q();
        bus.scl   = 1'b1; wait_q();
        m_sda_low = 1'b0; wait_q();
    endtask

    task automatic write_bit(input logic b);
        m_sda_low = ~b; wait_q();
        bus.scl   = 1'b1; wait_q(); wait_q();
        bus.scl   = 1'b0; wait_q();
    endtask

    task automatic read_bit(output logic b);
        m_sda_low = 1'b0; wait_q();
        bus.scl   = 1'b1; wait_q();
        b = sda_line;     wait_q();
        bus.scl   = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] d, input logic exp_ack, input string tag);
        logic a;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(a);
        check(tag, 32'(a), 32'(exp_ack));
    endtask

    task automatic recv_byte(input logic master_ack, input string tag);
        logic [7:0] d;
        logic       b;
        logic [7:0] e;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(master_ack);
        e = (rd_exp_q.size() != 0) ? rd_exp_q.pop_front() : 8'hxx;
        check(tag, 32'(d), 32'(e));
    endtask

    task automatic set_addr(input logic [15:0] a, input string tag);
        i2c_start();
        send_byte(8'hA0, ACK, {tag, "_dev_ack"});
        send_byte(a[15:8], ACK, {tag, "_ahi_ack"});
        send_byte(a[7:0], ACK, {tag, "_alo_ack"});
    endtask

    // ---------------- directed sequence ----------------
    int low_before;

    initial begin
        rst = 1'b1;
        m_sda_low = 1'b0;
        bus.scl = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_wr_en", 32'(bus.wr_en), 32'(0));
        check("rst_wr_addr", 32'(bus.wr_addr), 32'(0));
        check("rst_wr_data", 32'(bus.wr_data), 32'(0));
        check("rst_state", 32'(bus.state), 32'(IDLE));
        check("rst_sda", 32'(sda_line), 32'(1));
        rst = 1'b0;
        wait_q();

        // seed mem[0x02] = 0x03 for the current-address read later
        set_addr(16'h0002, "seed");
        wr_exp_q.push_back({8'h02, 8'h03});
        send_byte(8'h03, ACK, "seed_data_ack");
        i2c_stop();

        // byte write 0x5A -> 0x0012
        set_addr(16'h0012, "bw");
        check("bw_busy_high", 32'(bus.busy), 32'(1));
        wr_exp_q.push_back({8'h12, 8'h5A});
        send_byte(8'h5A, ACK, "bw_data_ack");
        i2c_stop();
        check("bw_busy_low", 32'(bus.busy), 32'(0));
        check("bw_wr_consumed", 32'(wr_exp_q.size()), 32'(0));

        // random read from 0x0012
        set_addr(16'h0012, "rr");
        i2c_start();
        send_byte(8'hA1, ACK, "rr_dev_ack");
        rd_exp_q.push_back(8'h5A);
        recv_byte(NACK, "rr_data");
        check("rr_sda_released", 32'(sda_line), 32'(1));
        check("rr_wait_stop", 32'(bus.state), 32'(WAIT_STOP));
        i2c_stop();

        // address mismatch: 0x52
        low_before = slave_low_cnt;
        i2c_start();
        send_byte(8'hA4, NACK, "mm_dev_nack");
        send_byte(8'h12, NACK, "mm_b1_nack");
        send_byte(8'h77, NACK, "mm_b2_nack");
        i2c_stop();
        check("mm_sda_never_low", 32'(slave_low_cnt - low_before), 32'(0));
        check("mm_busy_low", 32'(bus.busy), 32'(0));
        check("mm_state", 32'(bus.state), 32'(IDLE));

        // page write across the wrap point
        set_addr(16'h00FE, "wrap");
        wr_exp_q.push_back({8'hFE, 8'h01});
        wr_exp_q.push_back({8'hFF, 8'h02});
        wr_exp_q.push_back({8'h00, 8'h03});
        wr_exp_q.push_back({8'h01, 8'h04});
        for (int i = 1; i <= 4; i++) send_byte(8'(i), ACK, "wrap_data_ack");
        i2c_stop();
        check("wrap_wr_consumed", 32'(wr_exp_q.size()), 32'(0));

        // sequential read of 4 bytes from 0xFE
        set_addr(16'h00FE, "sr");
        i2c_start();
        send_byte(8'hA1, ACK, "sr_dev_ack");
        for (int i = 1; i <= 4; i++) rd_exp_q.push_back(8'(i));
        recv_byte(ACK, "sr_b0");
        recv_byte(ACK, "sr_b1");
        recv_byte(ACK, "sr_b2");
        recv_byte(NACK, "sr_b3");
        i2c_stop();

        // current-address read: pointer now 0x02
        i2c_start();
        send_byte(8'hA1, ACK, "cr_dev_ack");
        rd_exp_q.push_back(8'h03);
        recv_byte(NACK, "cr_data");
        i2c_stop();

        // STOP after 4 data bits
        set_addr(16'h0040, "sm");
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
        i2c_stop();
        check("sm_state", 32'(bus.state), 32'(IDLE));
        check("sm_busy", 32'(bus.busy), 32'(0));
        set_addr(16'h0010, "sm_next");
        wr_exp_q.push_back({8'h10, 8'h77});
        send_byte(8'h77, ACK, "sm_next_data_ack");
        i2c_stop();
        set_addr(16'h0010, "sm_rd");
        i2c_start();
        send_byte(8'hA1, ACK, "sm_rd_dev_ack");
        rd_exp_q.push_back(8'h77);
        recv_byte(NACK, "sm_rd_data");
        i2c_stop();

        // reset while the target drives SDA low (MSB of 0x77 is 0)
        set_addr(16'h0010, "rs");
        i2c_start();
        send_byte(8'hA1, ACK, "rs_dev_ack");
        check("rs_sda_driven", 32'(sda_line), 32'(0));
        check("rs_state_rd", 32'(bus.state), 32'(RD_DATA));
        rst = 1'b1;
        #1;
        check("rs_sda_released", 32'(sda_line), 32'(1));
        check("rs_busy", 32'(bus.busy), 32'(0));
        check("rs_wr_en", 32'(bus.wr_en), 32'(0));
        check("rs_state", 32'(bus.state), 32'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        m_sda_low = 1'b0;
        bus.scl = 1'b1;
        wait_q(); wait_q();
        check("rs_after_busy", 32'(bus.busy), 32'(0));
        check("rs_after_state", 32'(bus.state), 32'(IDLE));

        // ---------------- final report ----------------
        check("end_wr_q_empty", 32'(wr_exp_q.size()), 32'(0));
        check("end_rd_q_empty", 32'(rd_exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
